// File: rtl/go_button_ctrl.sv
// Button launcher: synchronise, debounce and edge-detect a raw button, then issue
// one-cycle go pulses gated by the downstream done. Optional one-deep press queue: GO_CTRL_QUEUE_EN.
module go_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W            = 16,
  parameter int RUN_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             done,
  output logic             go,
  output logic             busy,
  output logic             btn_clean,
  output logic             pending,
  output logic [RUN_W-1:0] runs
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_reg, state_next;
  logic             s1_reg, s2_reg;
  logic             clean_reg, prev_reg;
  logic [DB_W-1:0]  db_cnt_reg;
  logic [RUN_W-1:0] runs_reg;
  logic             press;
  logic             accept_done;
  logic             pending_int;

  assign press       = clean_reg & ~prev_reg;
  assign accept_done = (state_reg == WAIT) && done;

  // Clean level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      clean_reg  <= 1'b0;
      prev_reg   <= 1'b0;
      db_cnt_reg <= '0;
    end else begin
      s1_reg   <= btn;
      s2_reg   <= s1_reg;
      prev_reg <= clean_reg;
      if (s2_reg != clean_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          clean_reg  <= s2_reg;
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + DB_W'(1);
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      runs_reg <= '0;
    end else if (accept_done && (runs_reg != {RUN_W{1'b1}})) begin
      runs_reg <= runs_reg + RUN_W'(1);
    end
  end

`ifdef GO_CTRL_QUEUE_EN
  logic pending_reg;

  // A press taken together with done goes straight to ISSUE, so it never parks here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_reg <= 1'b0;
    end else if (accept_done) begin
      pending_reg <= 1'b0;
    end else if (press && (state_reg != IDLE)) begin
      pending_reg <= 1'b1;
    end
  end

  assign pending_int = pending_reg;
`else
  assign pending_int = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (press) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (done) begin
`ifdef GO_CTRL_QUEUE_EN
          state_next = (pending_int || press) ? ISSUE : IDLE;
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    go   = 1'b0;
    busy = 1'b0;
    case (state_reg)
      ISSUE: begin
        go   = 1'b1;
        busy = 1'b1;
      end
      WAIT:    busy = 1'b1;
      default: ;
    endcase
  end

  assign btn_clean = clean_reg;
  assign pending   = pending_int;
  assign runs      = runs_reg;

endmodule

// File: tb/tb_go_button_ctrl.sv
// Self-checking bench for go_button_ctrl (DEBOUNCE_CYCLES=4); expected go cycles
// are queued when a press is driven and matched as go pulses appear.
module tb_go_button_ctrl;
  localparam int DC  = 4;
  localparam int LAT = DC + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic       done = 1'b0;
  logic       go, busy, btn_clean, pending;
  logic [7:0] runs;

  int cyc = 0;
  int n_tests = 0;
  int n_fails = 0;
  int exp_runs = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  go_button_ctrl #(.DEBOUNCE_CYCLES(DC), .DB_W(16), .RUN_W(8)) dut (
    .clk(clk), .rst(rst), .btn(btn), .done(done),
    .go(go), .busy(busy), .btn_clean(btn_clean), .pending(pending), .runs(runs)
  );

  // Advance one cycle and service the go scoreboard.
  task automatic step_clk();
    int e;
    @(negedge clk);
    if (go === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL go_unexpected cycle=%0d got go=1 required go=0", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc !== e) begin
          n_fails++;
          $display("FAIL go_timing got cycle=%0d required cycle=%0d", cyc, e);
        end else begin
          $display("[TB] go at cycle %0d as expected", cyc);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0] < cyc) begin
      n_tests++;
      n_fails++;
      e = exp_q.pop_front();
      $display("FAIL go_missing got go=%b required go=1 at cycle=%0d", go, e);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step_clk();
  endtask

  task automatic pulse_done(input int width);
    done = 1'b1;
    run(width);
    done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; btn = 1'b1; done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      n_tests++;
      if ({go, busy, btn_clean, pending, runs} !== 12'h000) begin
        n_fails++;
        $display("FAIL reset_outputs got %h required 000", {go, busy, btn_clean, pending, runs});
      end
    end
    rst = 1'b1;
    exp_q.push_back(cyc + LAT);
    run(LAT + 1);
    n_tests++;
    if (busy !== 1'b1 || exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL reset_press got busy=%b pend_go=%0d required busy=1 pend_go=0", busy, exp_q.size());
    end
    btn = 1'b0;
    pulse_done(1);
    exp_runs = 1;
    n_tests++;
    if (runs !== 8'(exp_runs) || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_done got runs=%0d busy=%b required runs=%0d busy=0", runs, busy, exp_runs);
    end
    run(10);
    n_tests++;
    if (btn_clean !== 1'b0) begin
      n_fails++;
      $display("FAIL release_debounce got btn_clean=%b required 0", btn_clean);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_clean_press();
    int c0;
    step_clk();
    btn = 1'b1; c0 = cyc;
    exp_q.push_back(c0 + LAT);
    for (int k = 1; k <= 20; k++) begin
      step_clk();
      n_tests++;
      if (btn_clean !== (k >= DC + 2) || busy !== (k >= LAT)) begin
        n_fails++;
        $display("FAIL clean_press k=%0d got clean=%b busy=%b required clean=%b busy=%b",
                 k, btn_clean, busy, (k >= DC + 2), (k >= LAT));
      end
    end
    pulse_done(3);
    exp_runs++;
    n_tests++;
    if (runs !== 8'(exp_runs) || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL done_held got runs=%0d busy=%b required runs=%0d busy=0", runs, busy, exp_runs);
    end
    btn = 1'b0;
    run(10);
    $display("[TB] test_clean_press done");
  endtask

  task automatic test_bounce();
    int cf;
    step_clk(); btn = 1'b1;
    step_clk(); btn = 1'b0;
    step_clk(); btn = 1'b1;
    step_clk(); btn = 1'b0;
    step_clk(); btn = 1'b1;
    cf = cyc;
    exp_q.push_back(cf + LAT);
    for (int k = 1; k <= LAT + 2; k++) begin
      step_clk();
      n_tests++;
      if (btn_clean !== (k >= DC + 2)) begin
        n_fails++;
        $display("FAIL bounce_clean k=%0d got %b required %b", k, btn_clean, (k >= DC + 2));
      end
    end
    n_tests++;
    if (exp_q.size() != 0 || busy !== 1'b1) begin
      n_fails++;
      $display("FAIL bounce_go got pend_go=%0d busy=%b required 0 1", exp_q.size(), busy);
    end
    pulse_done(1);
    exp_runs++;
    n_tests++;
    if (runs !== 8'(exp_runs)) begin
      n_fails++;
      $display("FAIL bounce_runs got %0d required %0d", runs, exp_runs);
    end
    btn = 1'b0;
    run(10);
    $display("[TB] test_bounce done");
  endtask

  task automatic test_lockout_saturation();
    step_clk();
    btn = 1'b1;
    exp_q.push_back(cyc + LAT);
    run(LAT + 1);
    btn = 1'b0;
    run(8);
    btn = 1'b1;
    run(LAT + 3);
    n_tests++;
    if (busy !== 1'b1 || exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL lockout got busy=%b pend_go=%0d required busy=1 pend_go=0", busy, exp_q.size());
    end
`ifdef GO_CTRL_QUEUE_EN
    exp_q.push_back(cyc + 1);
    pulse_done(1);
    exp_runs++;
    run(2);
`endif
    pulse_done(1);
    exp_runs++;
    n_tests++;
    if (runs !== 8'(exp_runs) || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL lockout_done got runs=%0d busy=%b required runs=%0d busy=0", runs, busy, exp_runs);
    end
    btn = 1'b0;
    run(8);
    for (int i = 0; i < 256; i++) begin
      btn = 1'b1;
      exp_q.push_back(cyc + LAT);
      run(LAT + 1);
      pulse_done(1);
      exp_runs = (exp_runs < 255) ? exp_runs + 1 : 255;
      n_tests++;
      if (runs !== 8'(exp_runs)) begin
        n_fails++;
        $display("FAIL saturate_step i=%0d got runs=%0d required %0d", i, runs, exp_runs);
      end
      btn = 1'b0;
      run(DC + 3);
    end
    n_tests++;
    if (runs !== 8'hFF) begin
      n_fails++;
      $display("FAIL saturate_final got runs=%h required ff", runs);
    end
    $display("[TB] test_lockout_saturation done runs=%h", runs);
  endtask

  task automatic test_reset_mid_wait();
    step_clk();
    btn = 1'b1;
    exp_q.push_back(cyc + LAT);
    run(LAT + 1);
    btn = 1'b0;
    run(8);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fails++;
      $display("FAIL midwait_pre got busy=%b required 1", busy);
    end
    rst = 1'b0;
    step_clk();
    rst = 1'b1;
    exp_runs = 0;
    n_tests++;
    if (busy !== 1'b0 || runs !== 8'h00 || go !== 1'b0) begin
      n_fails++;
      $display("FAIL midwait_reset got busy=%b runs=%0d go=%b required 0 0 0", busy, runs, go);
    end
    run(3);
    pulse_done(1);
    run(2);
    n_tests++;
    if (runs !== 8'h00 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL midwait_done got runs=%0d busy=%b required 0 0", runs, busy);
    end
    $display("[TB] test_reset_mid_wait done");
  endtask

`ifdef GO_CTRL_QUEUE_EN
  task automatic test_queue();
    step_clk();
    btn = 1'b1;
    exp_q.push_back(cyc + LAT);
    run(LAT + 1);
    btn = 1'b0;
    run(8);
    n_tests++;
    if (pending !== 1'b0) begin
      n_fails++;
      $display("FAIL queue_idle got pending=%b required 0", pending);
    end
    btn = 1'b1;
    run(LAT);
    n_tests++;
    if (pending !== 1'b1) begin
      n_fails++;
      $display("FAIL queue_set got pending=%b required 1", pending);
    end
    btn = 1'b0;
    run(8);
    btn = 1'b1;
    run(LAT + 1);
    btn = 1'b0;
    run(8);
    exp_q.push_back(cyc + 1);
    pulse_done(1);
    exp_runs++;
    n_tests++;
    if (runs !== 8'(exp_runs) || pending !== 1'b0 || busy !== 1'b1) begin
      n_fails++;
      $display("FAIL queue_done got runs=%0d pending=%b busy=%b required %0d 0 1",
               runs, pending, busy, exp_runs);
    end
    run(2);
    pulse_done(1);
    exp_runs++;
    run(LAT + 3);
    n_tests++;
    if (runs !== 8'(exp_runs) || busy !== 1'b0 || exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL queue_drop got runs=%0d busy=%b pend_go=%0d required %0d 0 0",
               runs, busy, exp_q.size(), exp_runs);
    end
    $display("[TB] test_queue done");
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_lockout_saturation();
    test_reset_mid_wait();
`ifdef GO_CTRL_QUEUE_EN
    test_queue();
`endif
    run(LAT + 2);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL go_drain got %0d outstanding required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
